// File: rtl/digit_serializer.sv
// digit_serializer
// Captures DIGITS parallel digits on a load pulse and streams them out one at
// a time over a valid/ready handshake, oldest slot (DIGITS-1) first. GAP idle
// cycles separate an accepted digit from the next valid one, and done pulses
// for one cycle after the final digit is accepted. ledr mirrors the digit index.
//
// state | meaning
// IDLE  | waiting for load; valid/busy/done low, dout keeps the last digit
// SEND  | dout_valid high, digit held until dout_ready
// GAP   | idle spacing between an accepted digit and the next presentation
// DONE  | one-cycle done pulse after the final digit, then back to IDLE
module digit_serializer #(
    parameter int DIGITS = 6,
    parameter int WIDTH  = 4,
    parameter int GAP    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              ledr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
    localparam logic [3:0] GAP_CYC  = 4'(GAP);
    localparam bit         HAS_GAP  = (GAP > 0);

    state_t                  state;
    state_t                  state_n;
    logic [DIGITS*WIDTH-1:0] cap;
    logic [DIGITS*WIDTH-1:0] cap_n;
    logic [3:0]              gap_cnt;
    logic [3:0]              gap_cnt_n;
    logic [2:0]              idx;
    logic [2:0]              idx_n;
    logic [WIDTH-1:0]        dout_n;
    logic                    dout_valid_n;
    logic                    busy_n;
    logic                    done_n;
    logic                    xfer;
    logic                    last;

    // Index 0 maps to the oldest slot (DIGITS-1), index DIGITS-1 to slot 0.
    function automatic logic [WIDTH-1:0] slot_for(input logic [DIGITS*WIDTH-1:0] v,
                                                  input logic [2:0] i);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (i == 3'(DIGITS - 1 - k)) begin
                r = v[WIDTH*k +: WIDTH];
            end
        end
        return r;
    endfunction

    assign xfer = (state == S_SEND) && dout_valid && dout_ready;
    assign last = (idx == LAST_IDX);
    assign ledr = idx;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (load) begin
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last) begin
                        state_n = S_DONE;
                    end else if (HAS_GAP) begin
                        state_n = S_GAP;
                    end else begin
                        state_n = S_SEND;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= 4'd1) begin
                    state_n = S_SEND;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        cap_n        = cap;
        gap_cnt_n    = gap_cnt;
        idx_n        = idx;
        dout_n       = dout;
        dout_valid_n = dout_valid;
        busy_n       = busy;
        done_n       = 1'b0;
        case (state)
            S_IDLE: begin
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
                if (load) begin
                    // Present straight from din: cap only updates on this edge.
                    cap_n        = din;
                    idx_n        = 3'd0;
                    dout_n       = slot_for(din, 3'd0);
                    dout_valid_n = 1'b1;
                    busy_n       = 1'b1;
                end
            end
            S_SEND: begin
                dout_valid_n = 1'b1;
                busy_n       = 1'b1;
                if (xfer) begin
                    if (last) begin
                        dout_valid_n = 1'b0;
                        busy_n       = 1'b0;
                        done_n       = 1'b1;
                    end else begin
                        idx_n = idx + 3'd1;
                        if (HAS_GAP) begin
                            dout_valid_n = 1'b0;
                            gap_cnt_n    = GAP_CYC;
                        end else begin
                            dout_n = slot_for(cap, idx + 3'd1);
                        end
                    end
                end
            end
            S_GAP: begin
                dout_valid_n = 1'b0;
                if (gap_cnt <= 4'd1) begin
                    dout_n       = slot_for(cap, idx);
                    dout_valid_n = 1'b1;
                    gap_cnt_n    = 4'd0;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end
            S_DONE: begin
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
            end
            default: begin
                dout_valid_n = 1'b0;
                busy_n       = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset drops any in-flight digit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap        <= '0;
            gap_cnt    <= 4'd0;
            idx        <= 3'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cap        <= cap_n;
            gap_cnt    <= gap_cnt_n;
            idx        <= idx_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: doc/digit_serializer.md
Name: digit_serializer

Overview:
- Drain-side counterpart to the switch-entry / six-digit shift-display path.
- Captures six 4-bit digits in parallel on a load pulse, then emits them one digit at a time over a valid/ready stream, oldest slot first.
- Inserts a programmable idle gap between digits and pulses done after the last digit.
- Feeds a downstream serial consumer (UART formatter, logger, second display chain); ledr mirrors the digit index for board debug.

Parameters:
- DIGITS, 6: number of digit slots; legal range 2..8.
- WIDTH, 4: bits per digit.
- GAP, 2: idle cycles between accepted digit and next valid; legal range 0..15.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle request to capture din; honoured only in IDLE.
- din  input  DIGITS*WIDTH  parallel digits; slot i = din[WIDTH*i +: WIDTH]; slot DIGITS-1 is the oldest.
- dout  output  WIDTH  current digit, registered.
- dout_valid  output  1  dout holds a digit to transfer.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  high from the load-capture edge until DONE is entered.
- done  output  1  one-cycle pulse after the last digit is accepted.
- ledr  output  3  current digit index (0..DIGITS-1).

Behaviour:
- Clock is clock, rising edge. Reset is reset, asynchronous, active-low.
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (any time, including mid-transfer):
  - state=IDLE; dout=0, dout_valid=0, busy=0, done=0, ledr=0.
  - Capture register and gap counter cleared.
  - The in-flight digit is dropped.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - Outputs low.
  - On an edge with load=1: capture din, index=0, dout=slot DIGITS-1, dout_valid=1, busy=1, go to SEND.
  - Latency: dout_valid is visible in the cycle after the load edge.
- SEND:
  - dout_valid=1.
  - dout is slot DIGITS-1-index and must stay stable while dout_valid && !dout_ready.
  - Transfer occurs on an edge where dout_valid && dout_ready.
  - On transfer with index==DIGITS-1: dout_valid=0, busy=0, done=1, go to DONE.
  - On transfer otherwise: index+1.
    - GAP>0: dout_valid=0, gap counter=GAP, go to GAP.
    - GAP==0: load the next digit immediately and stay in SEND (back-to-back, one digit per cycle).
- GAP:
  - dout_valid=0; counter decrements each edge.
  - When counter==1: present the next digit, dout_valid=1, go to SEND.
  - Exactly GAP invalid cycles separate digits.
- DONE:
  - done=1 for exactly one cycle, then IDLE; done returns to 0.
- load outside IDLE (SEND, GAP, DONE) is ignored; the capture register is not disturbed.
- dout_ready outside SEND is ignored.
- dout retains the last digit after completion; only reset clears it.
- ledr = index; holds DIGITS-1 in DONE and returns to 0 on the next capture.
- Index counter 3 bits; never exceeds DIGITS-1 (no wrap).
- Full-transfer length with ready held high: DIGITS + (DIGITS-1)*GAP cycles of SEND/GAP, plus one DONE cycle.

Test Plan:
- Reset values: hold reset=0 with load=1 and random din -> dout=0, dout_valid=0, busy=0, done=0, ledr=0. After release, no activity until a load pulse.
- Basic order (defaults, ready=1): load at edge 0 with din=24'h654321.
  - dout_valid high in cycles 1, 4, 7, 10, 13, 16 with dout=6, 5, 4, 3, 2, 1.
  - ledr=0..5 in those cycles.
  - done=1 only in cycle 17; busy=0 from cycle 17; IDLE in cycle 18.
- Backpressure: same load, dout_ready=0 in cycles 4-6 -> dout=5 with dout_valid=1 held through cycles 4-7. Transfer at end of cycle 7; next digit 4 in cycle 10.
- Ignored load: pulse load with din=24'hFFFFFF in cycle 5 of a transfer -> sequence still 6, 5, 4, 3, 2, 1. A load in IDLE afterwards captures 24'hFFFFFF and emits six F digits.
- GAP=0 build, ready=1: din=24'hABCDEF -> dout=A, B, C, D, E, F on consecutive cycles 1-6; done in cycle 7.
- Reset mid-operation: assert reset in cycle 8 -> all outputs 0 immediately (asynchronous). After release, a load with din=24'h000009 emits 0, 0, 0, 0, 0, 9.
